avst_ready_latency_expander: RTL and testbench



---
 rtl/avst_adapter_pkg.sv | 17 +
 rtl/avst_skid_fifo2.sv | 50 +++++
 rtl/avst_ready_latency_expander.sv | 91 +++++++++
 tb/tb_avst_ready_latency_expander.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avst_adapter_pkg.sv
// Shared types and constants for the Avalon-ST ready-latency adapters.
package avst_adapter_pkg;

  localparam int MAX_READY_LATENCY = 4;

  typedef logic [1:0] fill_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/avst_skid_fifo2.sv
// Two-entry register FIFO; the caller guarantees no push when full and no pop when empty.
module avst_skid_fifo2
  import avst_adapter_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output fill_t             fill_level_o
);

  localparam int DEPTH = 2;
  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  fill_t             fill_q, fill_d;

  // Pointers are one bit wide, so the increments wrap modulo 2 on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    fill_d   = fill_q + fill_t'(push_i) - fill_t'(pop_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign fill_level_o = fill_q;

endmodule

// File: rtl/avst_ready_latency_expander.sv
// Bridges a ready-latency-0 source to a sink whose ready leads its data by
// OUT_READY_LATENCY cycles, using a 2-entry skid buffer and registered outputs.
module avst_ready_latency_expander
  import avst_adapter_pkg::*;
#(
  parameter int DATA_W            = 128,
  parameter int OUT_READY_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        fill_level
);

  localparam int L = OUT_READY_LATENCY;

  if (L < 1 || L > MAX_READY_LATENCY) begin : g_bad_latency
    $error("avst_ready_latency_expander: OUT_READY_LATENCY must be in 1..4");
  end

  fill_t             fill_q;
  logic [DATA_W-1:0] head;
  logic              slot_next;
  logic              push;
  logic              pop;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // in_ready looks only at the stored occupancy, never at in_valid or out_ready.
  assign in_ready = (fill_q < 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = slot_next & (fill_q != 2'd0);

  avst_skid_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (pop),
    .head_o      (head),
    .fill_level_o(fill_q)
  );

  // slot_next at an edge means out_ready was sampled high L-1 edges earlier.
  if (L == 1) begin : g_rp0
    assign slot_next = out_ready;
  end else if (L == 2) begin : g_rp1
    logic rp_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rp_q <= 1'b0;
      else          rp_q <= out_ready;
    end
    assign slot_next = rp_q;
  end else begin : g_rpn
    logic [L-2:0] rp_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rp_q <= '0;
      else          rp_q <= {rp_q[L-3:0], out_ready};
    end
    assign slot_next = rp_q[L-2];
  end

  // A granted slot with an empty buffer is simply forfeited; there is no bypass.
  always_comb begin
    out_valid_d = pop;
    out_data_d  = out_data_q;
    if (pop) out_data_d = head;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_avst_ready_latency_expander.sv
// Bench for avst_ready_latency_expander at ready latencies 1, 2 and 3.
module tb_avst_ready_latency_expander;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    in_valid, out_ready, in_ready, out_valid;
  logic [DW-1:0] in_data  [3];
  logic [DW-1:0] out_data [3];
  logic [1:0]    fill     [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    avst_ready_latency_expander #(
      .DATA_W           (DW),
      .OUT_READY_LATENCY(g + 1)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_data   (in_data[g]),
      .in_ready  (in_ready[g]),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g]),
      .fill_level(fill[g])
    );
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          orr;
    logic          ev;
    logic [DW-1:0] ed;
    logic [1:0]    ef;
    logic          eir;
  } vec_t;

  vec_t tbl [15];

  // Reference model: a queue of stored beats plus the history of sampled readies.
  int            act;
  logic [DW-1:0] mq [$];
  logic          rh [$];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rx [$];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (L=%0d t=%0t): got %0h expected %0h", name, act + 1, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    int   lat;
    logic granted;
    int   pre_size;
    lat = act + 1;
    if (lat == 1) granted = out_ready[act];
    else          granted = (rh.size() >= lat - 1) ? rh[lat-2] : 1'b0;
    pre_size = mq.size();
    if (granted && pre_size > 0) begin
      m_valid = 1'b1;
      m_data  = mq.pop_front();
    end else begin
      m_valid = 1'b0;
    end
    if (in_valid[act] && pre_size < 2) mq.push_back(in_data[act]);
    rh.push_front(out_ready[act]);
    if (rh.size() > 8) void'(rh.pop_back());
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid[act]), 32'(m_valid));
    chk("out_data", 32'(out_data[act]), 32'(m_data));
    chk("fill_level", 32'(fill[act]), 32'(mq.size()));
    chk("in_ready", 32'(in_ready[act]), 32'(mq.size() < 2));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (out_valid[act]) rx.push_back(out_data[act]);
    check_model();
  endtask

  task automatic clear_model();
    mq.delete();
    rh.delete();
    rx.delete();
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic idle_inputs();
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
  endtask

  task automatic do_reset(input int inst);
    reset_n = 1'b0;
    idle_inputs();
    act = inst;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 32'(out_valid[i]), 32'd0);
      chk("rst_out_data", 32'(out_data[i]), 32'd0);
      chk("rst_fill", 32'(fill[i]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[i]), 32'd1);
    end
    reset_n = 1'b1;
  endtask

  // Called one time unit after an edge; asserts reset between edges.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid[act]), 32'd0);
    chk("async_fill", 32'(fill[act]), 32'd0);
    chk("async_in_ready", 32'(in_ready[act]), 32'd1);
    chk("async_out_data", 32'(out_data[act]), 32'd0);
    clear_model();
    idle_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    act = 0;
    clear_model();

    tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 2'd1, 1'b1};
    tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 16'h0000, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0001, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 16'h0002, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 16'hdead, 1'b1, 1'b0, 16'h0002, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 16'hbeef, 1'b0, 1'b1, 16'h0003, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 2'd0, 1'b1};
    tbl[12] = '{1'b1, 16'h0005, 1'b1, 1'b0, 16'h0004, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0005, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0005, 2'd0, 1'b1};

    // L=2 backpressure, forfeited slot and no-bypass vectors
    do_reset(1);
    for (int r = 0; r < 15; r++) begin
      in_valid[1]  = tbl[r].iv;
      in_data[1]   = tbl[r].d;
      out_ready[1] = tbl[r].orr;
      tick();
      chk("tbl_out_valid", 32'(out_valid[1]), 32'(tbl[r].ev));
      chk("tbl_out_data", 32'(out_data[1]), 32'(tbl[r].ed));
      chk("tbl_fill", 32'(fill[1]), 32'(tbl[r].ef));
      chk("tbl_in_ready", 32'(in_ready[1]), 32'(tbl[r].eir));
    end

    // L=2 streaming 0x1..0x10 with out_ready held high
    do_reset(1);
    out_ready[1] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = DW'(k);
      tick();
      if (k >= 2) chk("stream_fill", 32'(fill[1]), 32'd1);
    end
    in_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("stream_count", 32'(rx.size()), 32'd16);
    for (int k = 0; k < rx.size() && k < 16; k++) chk("stream_order", 32'(rx[k]), 32'(k + 1));

    // L=2 reset while out_valid is high
    in_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[1] = DW'(16'h0100 + k);
      tick();
    end
    chk("pre_reset_valid", 32'(out_valid[1]), 32'd1);
    async_reset();

    // L=2 reset with a full buffer and a pending granted slot
    in_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[1] = DW'(16'h0200 + k);
      tick();
    end
    out_ready[1] = 1'b1;
    tick();
    chk("pre_reset_fill", 32'(fill[1]), 32'd2);
    async_reset();
    in_valid[1] = 1'b1;
    in_data[1]  = 16'h0300;
    tick();
    in_valid[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("post_reset_quiet", 32'(out_valid[1]), 32'd0);
    out_ready[1] = 1'b1;
    for (int k = 0; k < 3; k++) tick();

    // L=3 alternating out_ready with the buffer kept busy
    do_reset(2);
    for (int k = 0; k < 24; k++) begin
      in_valid[2]  = 1'b1;
      in_data[2]   = DW'(16'h0400 + k);
      out_ready[2] = (k % 2 == 0);
      tick();
    end

    // L=1 idle slots: no spurious beats, out_data holds while in_data wanders
    do_reset(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0a5a;
    out_ready[0] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = 1'b0;
      in_data[0]  = DW'($urandom);
      tick();
      chk("idle_hold", 32'(out_data[0]), 32'h0a5a);
    end

    // L=1 random traffic
    do_reset(0);
    for (int k = 0; k < 10000; k++) begin
      in_valid[0]  = 1'($urandom_range(0, 1));
      in_data[0]   = DW'($urandom);
      out_ready[0] = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("random_drained", 32'(fill[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
